// File: rtl/cache_ctrl_line.sv
//------------------------------------------------------------------------------
// Module      : cache_ctrl_line
// Description : Direct-mapped cache line controller with multi-word line fill.
//               Optional write-back/write-allocate mode via CACHE_CTRL_WB_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cache_ctrl_line #(
    parameter int WAIT_STATES = 4,
    parameter int LINE_WORDS  = 4,
    parameter int CTR_W       = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic Strobe,
    input  logic DRW,
    input  logic M,
    input  logic V,
    input  logic D,
    output logic DReady,
    output logic W,
    output logic WSel,
    output logic RSel,
    output logic MStrobe,
    output logic MRW,
    output logic MAddrSel,
    output logic [((LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1)-1:0] WordSel,
    output logic SetDirty
);

    localparam int                 c_IDX_W    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(LINE_WORDS - 1);
    localparam logic [CTR_W-1:0]   c_WAIT     = CTR_W'(WAIT_STATES);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_READ      = 4'd1,
        S_WRITE     = 4'd2,
        S_FILL_REQ  = 4'd3,
        S_FILL_WAIT = 4'd4,
        S_FILL_DATA = 4'd5,
        S_RD_DONE   = 4'd6,
`ifdef CACHE_CTRL_WB_EN
        S_EVICT_REQ  = 4'd10,
        S_EVICT_WAIT = 4'd11,
        S_WR_ALLOC   = 4'd12
`else
        S_WMEM_REQ  = 4'd7,
        S_WMEM_WAIT = 4'd8,
        S_WR_DONE   = 4'd9
`endif
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [c_IDX_W-1:0] r_index, w_index_nxt;
    logic [CTR_W-1:0]   r_cnt,   w_cnt_nxt;
    logic               w_hit;

    assign w_hit   = M & V;
    assign WordSel = r_index;
    // Read data always comes from the cache: a miss completes only after the fill.
    assign RSel    = 1'b0;

`ifdef CACHE_CTRL_WB_EN
    logic r_is_write, w_is_write_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_is_write <= 1'b0;
        else          r_is_write <= w_is_write_nxt;
    end
`else
    logic w_unused_d;
    assign w_unused_d = D;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_index <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_index <= w_index_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_index_nxt = r_index;
        w_cnt_nxt   = r_cnt;
        DReady      = 1'b0;
        W           = 1'b0;
        WSel        = 1'b0;
        MStrobe     = 1'b0;
        MRW         = 1'b0;
        MAddrSel    = 1'b0;
        SetDirty    = 1'b0;
`ifdef CACHE_CTRL_WB_EN
        w_is_write_nxt = r_is_write;
`endif
        case (r_state)
            S_IDLE: begin
                if (Strobe) begin
`ifdef CACHE_CTRL_WB_EN
                    w_is_write_nxt = DRW;
`endif
                    w_state_nxt = DRW ? S_WRITE : S_READ;
                end
            end
            S_READ: begin
                if (w_hit) begin
                    DReady      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_index_nxt = '0;
`ifdef CACHE_CTRL_WB_EN
                    w_state_nxt = (V & D) ? S_EVICT_REQ : S_FILL_REQ;
`else
                    w_state_nxt = S_FILL_REQ;
`endif
                end
            end
            S_WRITE: begin
`ifdef CACHE_CTRL_WB_EN
                if (w_hit) begin
                    W           = 1'b1;
                    SetDirty    = 1'b1;
                    DReady      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_index_nxt = '0;
                    w_state_nxt = (V & D) ? S_EVICT_REQ : S_FILL_REQ;
                end
`else
                W           = w_hit;
                w_state_nxt = S_WMEM_REQ;
`endif
            end
            S_FILL_REQ: begin
                MStrobe     = 1'b1;
                w_cnt_nxt   = c_WAIT;
                w_state_nxt = S_FILL_WAIT;
            end
            S_FILL_WAIT: begin
                if (r_cnt != '0) w_cnt_nxt = r_cnt - CTR_W'(1);
                if (r_cnt <= CTR_W'(1)) w_state_nxt = S_FILL_DATA;
            end
            S_FILL_DATA: begin
                W    = 1'b1;
                WSel = 1'b1;
                if (r_index == c_LAST_IDX) begin
                    w_index_nxt = '0;
`ifdef CACHE_CTRL_WB_EN
                    w_state_nxt = r_is_write ? S_WR_ALLOC : S_RD_DONE;
`else
                    w_state_nxt = S_RD_DONE;
`endif
                end else begin
                    w_index_nxt = r_index + c_IDX_W'(1);
                    w_state_nxt = S_FILL_REQ;
                end
            end
            S_RD_DONE: begin
                DReady      = 1'b1;
                w_state_nxt = S_IDLE;
            end
`ifdef CACHE_CTRL_WB_EN
            S_EVICT_REQ: begin
                MStrobe     = 1'b1;
                MRW         = 1'b1;
                MAddrSel    = 1'b1;
                w_cnt_nxt   = c_WAIT;
                w_state_nxt = S_EVICT_WAIT;
            end
            // Counts down to zero inclusive: the extra beat keeps evict words on
            // the same REQ-to-REQ cadence as fill words.
            S_EVICT_WAIT: begin
                MRW      = 1'b1;
                MAddrSel = 1'b1;
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CTR_W'(1);
                end else if (r_index == c_LAST_IDX) begin
                    w_index_nxt = '0;
                    w_state_nxt = S_FILL_REQ;
                end else begin
                    w_index_nxt = r_index + c_IDX_W'(1);
                    w_state_nxt = S_EVICT_REQ;
                end
            end
            S_WR_ALLOC: begin
                W           = 1'b1;
                SetDirty    = 1'b1;
                DReady      = 1'b1;
                w_state_nxt = S_IDLE;
            end
`else
            S_WMEM_REQ: begin
                MStrobe     = 1'b1;
                MRW         = 1'b1;
                w_cnt_nxt   = c_WAIT;
                w_state_nxt = S_WMEM_WAIT;
            end
            S_WMEM_WAIT: begin
                MRW = 1'b1;
                if (r_cnt != '0) w_cnt_nxt = r_cnt - CTR_W'(1);
                if (r_cnt <= CTR_W'(1)) w_state_nxt = S_WR_DONE;
            end
            S_WR_DONE: begin
                DReady      = 1'b1;
                w_state_nxt = S_IDLE;
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

endmodule

`default_nettype wire
